// File: rtl/lutram_fwft_fifo_pkg.sv
// Shared types and helpers for the LUTRAM FWFT FIFO slice.
// Holds the occupancy-step encoding and the count-width helper.
package lutram_fwft_fifo_pkg;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_UP   = 2'd1,
    OCC_DOWN = 2'd2
  } occ_op_e;

  function automatic int unsigned f_cnt_w(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lutram_fwft_fifo_if.sv
// FIFO bus: producer push/data_in, consumer pop/data_out, status flags.
// master = the side driving push/pop, slave = the FIFO itself.
interface lutram_fwft_fifo_if
  import lutram_fwft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = f_cnt_w(DEPTH);

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output push, data_in, pop,
    input  data_out, valid, empty,
    input  almost_empty, almost_full, full,
    input  count, overflow_err, underflow_err
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid, empty,
    output almost_empty, almost_full, full,
    output count, overflow_err, underflow_err
  );

endinterface

// File: rtl/lutram_fwft_fifo_ptr_ctrl.sv
// Pointer/occupancy control: wrap pointers, one-hot occ, count, errors.
// Ports: clk/rst, i_push/i_pop in; accepts, pointers, flags, count out.
module lutram_fwft_fifo_ptr_ctrl
  import lutram_fwft_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  output logic          o_push_acc,
  output logic          o_pop_acc,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic          o_empty,
  output logic          o_almost_empty,
  output logic          o_almost_full,
  output logic          o_full,
  output logic [CW-1:0] o_count,
  output logic          o_overflow_err,
  output logic          o_underflow_err
);

  localparam logic [DEPTH:0] OCC_RST = {{DEPTH{1'b0}}, 1'b1};

  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [DEPTH:0] r_occ;
  logic [CW-1:0]  r_count;
  logic           r_ovf;
  logic           r_unf;

  logic    w_push_acc;
  logic    w_pop_acc;
  occ_op_e w_op;

  // Wrap by compare so non power-of-two depths work.
  function automatic logic [PW-1:0] f_next(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop_acc  = i_pop & ~r_occ[0];
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push_acc = i_push & (~r_occ[DEPTH] | w_pop_acc);

  always_comb begin
    w_op = OCC_HOLD;
    unique case (1'b1)
      (w_push_acc & ~w_pop_acc): w_op = OCC_UP;
      (w_pop_acc & ~w_push_acc): w_op = OCC_DOWN;
      default:                   w_op = OCC_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_occ   <= OCC_RST;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push_acc) r_wr <= f_next(r_wr);
      if (w_pop_acc)  r_rd <= f_next(r_rd);
      unique case (w_op)
        OCC_UP: begin
          r_occ   <= {r_occ[DEPTH-1:0], 1'b0};
          r_count <= r_count + CW'(1);
        end
        OCC_DOWN: begin
          r_occ   <= {1'b0, r_occ[DEPTH:1]};
          r_count <= r_count - CW'(1);
        end
        default: begin
          r_occ   <= r_occ;
          r_count <= r_count;
        end
      endcase
      if (i_push & r_occ[DEPTH] & ~w_pop_acc) r_ovf <= 1'b1;
      if (i_pop & r_occ[0])                   r_unf <= 1'b1;
    end
  end

  assign o_push_acc      = w_push_acc;
  assign o_pop_acc       = w_pop_acc;
  assign o_wr_ptr        = r_wr;
  assign o_rd_ptr        = r_rd;
  assign o_empty         = r_occ[0];
  assign o_almost_empty  = r_occ[1];
  assign o_almost_full   = r_occ[DEPTH-1];
  assign o_full          = r_occ[DEPTH];
  assign o_count         = r_count;
  assign o_overflow_err  = r_ovf;
  assign o_underflow_err = r_unf;

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot(r_occ));

  a_cnt_occ: assert property (
    @(posedge clk) disable iff (rst) r_occ[r_count]);

  a_ptr_inv: assert property (
    @(posedge clk) disable iff (rst)
    int'(r_wr) == (int'(r_rd) + int'(r_count)) % DEPTH);

  a_no_ovf_acc: assert property (
    @(posedge clk) disable iff (rst)
    !(w_push_acc && r_occ[DEPTH] && !w_pop_acc));
`endif

endmodule

// File: rtl/lutram_fwft_fifo.sv
// First-word-fall-through FIFO on distributed RAM, async head read.
// Ports: clk, rst (async, active-high), bus (slave side of fifo if).
module lutram_fwft_fifo
  import lutram_fwft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  lutram_fwft_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = f_cnt_w(DEPTH);

  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_empty;
  logic [CW-1:0]         w_count;

  // Storage is deliberately not reset so it maps onto LUTRAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  lutram_fwft_fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .i_push          (bus.push),
    .i_pop           (bus.pop),
    .o_push_acc      (w_push_acc),
    .o_pop_acc       (w_pop_acc),
    .o_wr_ptr        (w_wr_ptr),
    .o_rd_ptr        (w_rd_ptr),
    .o_empty         (w_empty),
    .o_almost_empty  (bus.almost_empty),
    .o_almost_full   (bus.almost_full),
    .o_full          (bus.full),
    .o_count         (w_count),
    .o_overflow_err  (bus.overflow_err),
    .o_underflow_err (bus.underflow_err)
  );

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[w_wr_ptr] <= bus.data_in;
  end

  // Head entry is combinational: no read latency.
  assign bus.data_out = r_mem[w_rd_ptr];
  assign bus.valid    = ~w_empty;
  assign bus.empty    = w_empty;
  assign bus.count    = w_count;

  logic w_unused;
  assign w_unused = w_pop_acc;

endmodule

// File: tb/tb_lutram_fwft_fifo.sv
// Randomised + directed bench for lutram_fwft_fifo, DEPTH 4 and 3.
// Queue-based reference model; one check task for all comparisons.
module tb_lutram_fwft_fifo;

  logic clk  = 1'b0;
  logic rst4 = 1'b1;
  logic rst3 = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mq[$];
  int          mdepth;
  bit          movf;
  bit          munf;

  lutram_fwft_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) if4 ();
  lutram_fwft_fifo_if #(.DATA_WIDTH(32), .DEPTH(3)) if3 ();

  lutram_fwft_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  lutram_fwft_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset(int depth);
    mq.delete();
    mdepth = depth;
    movf   = 1'b0;
    munf   = 1'b0;
  endfunction

  function automatic void model_step(bit p, bit q, logic [31:0] d);
    int  n;
    bit  pa;
    bit  pu;
    n  = mq.size();
    pa = q && (n > 0);
    pu = p && ((n < mdepth) || pa);
    if (p && n == mdepth && !pa) movf = 1'b1;
    if (q && n == 0)             munf = 1'b1;
    if (pa) void'(mq.pop_front());
    if (pu) mq.push_back(d);
  endfunction

  task automatic check_all(int id);
    logic [31:0] dout;
    logic [31:0] cnt;
    logic        v, e, ae, af, f, ov, un;
    int          n;
    string       pfx;
    if (id == 0) begin
      dout = if4.data_out;  cnt = 32'(if4.count);
      v = if4.valid;  e = if4.empty;  ae = if4.almost_empty;
      af = if4.almost_full;  f = if4.full;
      ov = if4.overflow_err;  un = if4.underflow_err;
    end else begin
      dout = if3.data_out;  cnt = 32'(if3.count);
      v = if3.valid;  e = if3.empty;  ae = if3.almost_empty;
      af = if3.almost_full;  f = if3.full;
      ov = if3.overflow_err;  un = if3.underflow_err;
    end
    n   = mq.size();
    pfx = (id == 0) ? "d4" : "d3";
    check({pfx, ".count"}, cnt, 32'(n));
    check({pfx, ".valid"}, 32'(v), 32'(n > 0));
    check({pfx, ".empty"}, 32'(e), 32'(n == 0));
    check({pfx, ".aempty"}, 32'(ae), 32'(n == 1));
    check({pfx, ".afull"}, 32'(af), 32'(n == mdepth - 1));
    check({pfx, ".full"}, 32'(f), 32'(n == mdepth));
    check({pfx, ".ovf"}, 32'(ov), 32'(movf));
    check({pfx, ".unf"}, 32'(un), 32'(munf));
    if (n > 0) check({pfx, ".head"}, dout, mq[0]);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(int id, bit p, bit q, logic [31:0] d);
    if (id == 0) begin
      if4.push = p;  if4.pop = q;  if4.data_in = d;
    end else begin
      if3.push = p;  if3.pop = q;  if3.data_in = d;
    end
    @(posedge clk);
    model_step(p, q, d);
    @(negedge clk);
    if (id == 0) begin
      if4.push = 1'b0;  if4.pop = 1'b0;
    end else begin
      if3.push = 1'b0;  if3.pop = 1'b0;
    end
    check_all(id);
  endtask

  logic [31:0] exp_v[4];

  initial begin
    if4.push = 1'b0;  if4.pop = 1'b0;  if4.data_in = '0;
    if3.push = 1'b0;  if3.pop = 1'b0;  if3.data_in = '0;

    // reset, idle
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    rst3 = 1'b0;
    repeat (2) @(negedge clk);
    model_reset(3);
    check_all(1);
    model_reset(4);
    check_all(0);

    // three pushes then drain in order
    step(0, 1, 0, 32'hA1);
    step(0, 1, 0, 32'hA2);
    step(0, 1, 0, 32'hA3);
    check("t2.afull", 32'(if4.almost_full), 32'd1);
    check("t2.head", if4.data_out, 32'hA1);
    for (int i = 0; i < 3; i++) begin
      check("t2.pop", if4.data_out, 32'hA1 + 32'(i));
      step(0, 0, 1, '0);
    end
    check("t2.empty", 32'(if4.empty), 32'd1);

    // overflow while full
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h10 + 32'(i));
    step(0, 1, 0, 32'hFF);
    check("t3.ovf", 32'(if4.overflow_err), 32'd1);
    check("t3.count", 32'(if4.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3.drain", if4.data_out, 32'h10 + 32'(i));
      step(0, 0, 1, '0);
    end

    // push+pop at full, pointers wrap
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hD0 + 32'(i));
    for (int i = 0; i < 10; i++) step(0, 1, 1, 32'hB5 + 32'(i));
    check("t4.count", 32'(if4.count), 32'd4);
    for (int i = 0; i < 4; i++) exp_v[i] = 32'hBB + 32'(i);
    for (int i = 0; i < 4; i++) begin
      check("t4.drain", if4.data_out, exp_v[i]);
      step(0, 0, 1, '0);
    end

    // pop on empty with same-cycle push
    step(0, 1, 1, 32'hC1);
    check("t5.unf", 32'(if4.underflow_err), 32'd1);
    check("t5.count", 32'(if4.count), 32'd1);
    check("t5.head", if4.data_out, 32'hC1);
    step(0, 0, 1, '0);

    // DEPTH=3 random traffic
    model_reset(3);
    check_all(1);
    for (int i = 0; i < 20; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom);
    end
    step(1, 1, 0, 32'h5A);
    step(1, 1, 0, 32'h5B);

    // async reset mid-stream
    rst3 = 1'b1;
    #1;
    model_reset(3);
    check_all(1);
    @(negedge clk);
    rst3 = 1'b0;
    check_all(1);
    for (int i = 0; i < 6; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
